// File: rtl/kernel_launch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : kernel_launch_queue
//  Purpose  : Buffers kernel launch requests (thread count + tag) in a small
//             FIFO and runs them one at a time through the block dispatcher.
//             Each kernel goes through these steps: the dispatcher is held in
//             reset, the thread count is presented, start is held until done,
//             and then a completion record with the tag and the RUN-cycle
//             count is emitted.
//  Ports    : clk, reset                 - clock, synchronous active-high reset
//             launch_valid/ready/
//             launch_thread_count/tag    - launch request handshake
//             abort                      - terminate running kernel (level)
//             disp_reset/start/
//             thread_count, disp_done    - dispatcher control / status
//             cmpl_valid/tag/cycles/
//             aborted                    - one-cycle completion record
//             queue_level, busy          - occupancy / activity status
//  Revision : 1.0 - initial release
// ============================================================================
module kernel_launch_queue #(
   parameter int QUEUE_DEPTH = 4,
   parameter int TAG_W       = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           launch_valid,
   output logic                           launch_ready,
   input  logic [7:0]                     launch_thread_count,
   input  logic [TAG_W-1:0]               launch_tag,
   input  logic                           abort,
   output logic                           disp_reset,
   output logic                           disp_start,
   output logic [7:0]                     disp_thread_count,
   input  logic                           disp_done,
   output logic                           cmpl_valid,
   output logic [TAG_W-1:0]               cmpl_tag,
   output logic [15:0]                    cmpl_cycles,
   output logic                           cmpl_aborted,
   output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
   output logic                           busy
);

   localparam int PTR_W   = $clog2(QUEUE_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENTRY_W = 8 + TAG_W;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD     = 2'd1,
      ST_RUN      = 2'd2,
      ST_COMPLETE = 2'd3
   } state_t;

   state_t             state;

   // ------------------------------------------------------------------
   // Launch FIFO
   // ------------------------------------------------------------------
   logic [ENTRY_W-1:0] mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   level;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head;

   assign fifo_full  = (level == LVL_W'(QUEUE_DEPTH));
   assign fifo_empty = (level == '0);
   assign push       = launch_valid && !fifo_full;
   // Entries leave the FIFO only on the transition into LOAD. Because the
   // state is registered, a freshly pushed entry cannot be popped in the
   // cycle in which it is written.
   assign pop        = !fifo_empty && ((state == ST_IDLE) || (state == ST_COMPLETE));
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {launch_tag, launch_thread_count};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Kernel sequencer
   // ------------------------------------------------------------------
   logic [7:0]       cur_count;
   logic [TAG_W-1:0] cur_tag;
   logic [15:0]      cycles;
   logic             aborted;
   logic [15:0]      cycles_inc;

   assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;

   // The dispatcher controls and the completion pulse are registered to
   // match the state they belong to, so each is computed from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         disp_reset <= 1'b1;
         disp_start <= 1'b0;
         cmpl_valid <= 1'b0;
         cur_count  <= '0;
         cur_tag    <= '0;
         cycles     <= '0;
         aborted    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               disp_reset <= 1'b1;
               disp_start <= 1'b0;
               cmpl_valid <= 1'b0;
               if (pop) begin
                  state     <= ST_LOAD;
                  cur_count <= head[7:0];
                  cur_tag   <= head[8 +: TAG_W];
               end
            end

            ST_LOAD: begin
               cycles  <= '0;
               aborted <= 1'b0;
               if (cur_count == 8'd0) begin
                  // Empty kernel: complete without ever starting the dispatcher.
                  state      <= ST_COMPLETE;
                  cmpl_valid <= 1'b1;
               end else begin
                  state      <= ST_RUN;
                  disp_reset <= 1'b0;
                  disp_start <= 1'b1;
               end
            end

            ST_RUN: begin
               // The exit cycle is counted as well.
               cycles <= cycles_inc;
               if (disp_done || abort) begin
                  state      <= ST_COMPLETE;
                  aborted    <= !disp_done;   // done wins over abort
                  disp_reset <= 1'b1;
                  disp_start <= 1'b0;
                  cmpl_valid <= 1'b1;
               end
            end

            ST_COMPLETE: begin
               cmpl_valid <= 1'b0;
               if (pop) begin
                  state     <= ST_LOAD;
                  cur_count <= head[7:0];
                  cur_tag   <= head[8 +: TAG_W];
               end else begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state      <= ST_IDLE;
               disp_reset <= 1'b1;
               disp_start <= 1'b0;
               cmpl_valid <= 1'b0;
            end
         endcase
      end
   end

   assign launch_ready      = !fifo_full;
   assign disp_thread_count = cur_count;
   assign cmpl_tag          = cur_tag;
   assign cmpl_cycles       = cycles;
   assign cmpl_aborted      = aborted;
   assign queue_level       = level;
   assign busy              = (state != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_kernel_launch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kernel_launch_queue
//  Purpose  : Self-checking bench for kernel_launch_queue. A behavioural
//             dispatcher drives done and abort according to a per-kernel plan.
//             An in-order queue of planned kernels predicts every completion
//             record: the run length is min(done cycle, abort cycle), and the
//             reported cycle count saturates at 65535.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_launch_queue;

   localparam int DEPTH = 4;
   localparam int TW    = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          launch_valid = 1'b0;
   logic          launch_ready;
   logic [7:0]    launch_thread_count = '0;
   logic [TW-1:0] launch_tag = '0;
   logic          abort;
   logic          disp_reset;
   logic          disp_start;
   logic [7:0]    disp_thread_count;
   logic          disp_done;
   logic          cmpl_valid;
   logic [TW-1:0] cmpl_tag;
   logic [15:0]   cmpl_cycles;
   logic          cmpl_aborted;
   logic [$clog2(DEPTH):0] queue_level;
   logic          busy;

   kernel_launch_queue #(.QUEUE_DEPTH(DEPTH), .TAG_W(TW)) dut (
      .clk                 (clk),
      .reset               (reset),
      .launch_valid        (launch_valid),
      .launch_ready        (launch_ready),
      .launch_thread_count (launch_thread_count),
      .launch_tag          (launch_tag),
      .abort               (abort),
      .disp_reset          (disp_reset),
      .disp_start          (disp_start),
      .disp_thread_count   (disp_thread_count),
      .disp_done           (disp_done),
      .cmpl_valid          (cmpl_valid),
      .cmpl_tag            (cmpl_tag),
      .cmpl_cycles         (cmpl_cycles),
      .cmpl_aborted        (cmpl_aborted),
      .queue_level         (queue_level),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   // A planned kernel: done in RUN cycle d, abort in RUN cycle a (0 = never).
   typedef struct {
      logic [7:0]    cnt;
      logic [TW-1:0] tg;
      int            d;
      int            a;
   } kern_t;

   kern_t pending[$];
   int    checks = 0;
   int    errors = 0;
   bit    noise_en = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Dispatcher model + completion monitor (all on the falling edge)
   // ------------------------------------------------------------------
   int run_seen;
   int start_cnt;
   int gap;
   int last_gap;
   bit seen_start;
   bit prev_start;

   always @(negedge clk) begin
      if (reset) begin
         disp_done  = 1'b0;
         abort      = 1'b0;
         run_seen   = 0;
         start_cnt  = 0;
         gap        = 0;
         seen_start = 1'b0;
         prev_start = 1'b0;
      end else begin
         check_eq("reset_vs_start", disp_reset, !disp_start);
         run_seen = disp_start ? run_seen + 1 : 0;
         if (disp_start) begin
            start_cnt++;
            if (!prev_start) begin
               if (seen_start) check_eq("reset_gap_ge2", gap >= 2, 1);
               last_gap   = gap;
               seen_start = 1'b1;
            end
            gap = 0;
         end else if (disp_reset) begin
            gap++;
         end
         prev_start = disp_start;

         if (disp_reset) disp_done = 1'b0;
         if (disp_start && pending.size() > 0) begin
            check_eq("thread_count", disp_thread_count, pending[0].cnt);
            if (run_seen == pending[0].d) disp_done = 1'b1;
            abort = (run_seen == pending[0].a);
         end else begin
            abort = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
         end

         if (cmpl_valid) begin
            if (pending.size() == 0) begin
               check_eq("cmpl_unexpected", cmpl_valid, 0);
            end else begin
               kern_t h;
               int    run;
               bit    ab;
               h = pending.pop_front();
               if (h.cnt == 0) begin
                  run = 0; ab = 1'b0;
               end else if (h.a > 0 && h.a < h.d) begin
                  run = h.a; ab = 1'b1;
               end else begin
                  run = h.d; ab = 1'b0;
               end
               check_eq("cmpl_tag", cmpl_tag, h.tg);
               check_eq("cmpl_cycles", cmpl_cycles, (run > 65535) ? 65535 : run);
               check_eq("cmpl_aborted", cmpl_aborted, ab);
               check_eq("start_cycles", start_cnt, run);
            end
            start_cnt = 0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (called just after a falling edge)
   // ------------------------------------------------------------------
   task automatic send(input logic [7:0] c, input logic [TW-1:0] t, input int d, input int a);
      int n = 0;
      launch_valid        = 1'b1;
      launch_thread_count = c;
      launch_tag          = t;
      while (!launch_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("send_ready", launch_ready, 1);
      if (launch_ready) pending.push_back('{c, t, d, a});
      @(negedge clk);
      launch_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || pending.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("idle_reached", n < budget, 1);
   endtask

   initial begin
      abort     = 1'b0;
      disp_done = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset values
      check_eq("rst_level", queue_level, 0);
      check_eq("rst_ready", launch_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_disp_reset", disp_reset, 1);
      check_eq("rst_disp_start", disp_start, 0);
      check_eq("rst_thread_count", disp_thread_count, 0);
      check_eq("rst_cmpl_valid", cmpl_valid, 0);
      check_eq("rst_cmpl_tag", cmpl_tag, 0);
      check_eq("rst_cmpl_cycles", cmpl_cycles, 0);
      check_eq("rst_cmpl_aborted", cmpl_aborted, 0);

      // Single kernel: accepted in cycle T, done in the 5th RUN cycle
      @(negedge clk);
      launch_valid = 1'b1; launch_thread_count = 8'd8; launch_tag = 4'd3;
      pending.push_back('{8'd8, 4'd3, 5, 0});
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 1) launch_valid = 1'b0;
         if (i == 1) check_eq("single_level1", queue_level, 1);
         check_eq("single_start", disp_start, (i >= 3 && i <= 7));
         check_eq("single_cmpl", cmpl_valid, (i == 8));
      end

      // Zero thread count: LOAD then COMPLETE, dispatcher never started
      launch_valid = 1'b1; launch_thread_count = 8'd0; launch_tag = 4'd1;
      pending.push_back('{8'd0, 4'd1, 5, 0});
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) launch_valid = 1'b0;
         check_eq("zero_start", disp_start, 0);
         check_eq("zero_cmpl", cmpl_valid, (i == 3));
      end

      // Backpressure: 5 back-to-back requests while a long kernel runs
      send(8'd20, 4'd10, 60, 0);
      repeat (2) @(negedge clk);
      check_eq("bp_running", disp_start, 1);
      for (int j = 0; j < 5; j++) begin
         check_eq("bp_ready", launch_ready, (j < 4));
         if (j == 4) check_eq("bp_level_full", queue_level, 4);
         send(8'(j + 1), 4'(j + 11), 3 + j, 0);
      end
      wait_idle(500);
      check_eq("b2b_gap", last_gap, 2);

      // Abort on 3rd RUN cycle; abort coincident with done
      send(8'd5, 4'd6, 10, 3);
      send(8'd5, 4'd7, 4, 4);
      wait_idle(200);

      // Abort while idle has no effect
      noise_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("idle_abort_busy", busy, 0);
         check_eq("idle_abort_cmpl", cmpl_valid, 0);
      end
      noise_en = 1'b0;

      // Reset mid-run with two entries queued
      send(8'd30, 4'd2, 500, 0);
      begin
         int n = 0;
         while (!disp_start && n < 20) begin @(negedge clk); n++; end
      end
      check_eq("mid_running", disp_start, 1);
      send(8'd4, 4'd8, 5, 0);
      send(8'd4, 4'd9, 5, 0);
      check_eq("mid_level2", queue_level, 2);
      reset = 1'b1;
      pending.delete();
      @(negedge clk);
      check_eq("mid_cmpl", cmpl_valid, 0);
      check_eq("mid_level", queue_level, 0);
      check_eq("mid_disp_reset", disp_reset, 1);
      check_eq("mid_busy", busy, 0);
      check_eq("mid_start", disp_start, 0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("post_rst_cmpl", cmpl_valid, 0);
      end

      // Counter saturation
      send(8'd9, 4'd5, 70000, 0);
      wait_idle(71000);

      // Randomized traffic with abort noise outside RUN
      noise_en = 1'b1;
      for (int k = 0; k < 150; k++) begin
         logic [7:0] c;
         int         a;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         c = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
         send(c, 4'($urandom_range(0, 15)), int'($urandom_range(1, 12)), a);
      end
      wait_idle(2000);
      noise_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
